// File: rtl/volatility_window_stats_if.sv
// Sample/result bundle between the address controller, the window-stats block and
// its consumer. master drives samples and observes results; slave is the stats block.
interface volatility_window_stats_if #(
  parameter int NUM_STOCKS  = 4,
  parameter int BUFFER_SIZE = 20,
  parameter int DATA_WIDTH  = 32
);
  localparam int DEPTH = NUM_STOCKS * BUFFER_SIZE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int CW    = $clog2(BUFFER_SIZE + 1);
  localparam int SW    = DATA_WIDTH + CW;
  localparam int VW    = 2 * DATA_WIDTH + 2 * CW;

  logic                  i_addr_valid;
  logic [AW-1:0]         i_write_address;
  logic [IW-1:0]         i_stock_id;
  logic [DATA_WIDTH-1:0] i_price;
  logic [DATA_WIDTH-1:0] i_buffer_size;
  logic                  o_valid;
  logic [IW-1:0]         o_stock_id;
  logic [CW-1:0]         o_count;
  logic [SW-1:0]         o_sum;
  logic [VW-1:0]         o_var_num;
  logic                  o_window_full;
  logic                  o_addr_err;

  modport master (
    output i_addr_valid, i_write_address, i_stock_id, i_price, i_buffer_size,
    input  o_valid, o_stock_id, o_count, o_sum, o_var_num, o_window_full, o_addr_err
  );

  modport slave (
    input  i_addr_valid, i_write_address, i_stock_id, i_price, i_buffer_size,
    output o_valid, o_stock_id, o_count, o_sum, o_var_num, o_window_full, o_addr_err
  );
endinterface

// File: rtl/volatility_window_stats.sv
// Per-stock circular price window with running count/sum/sum-of-squares and a
// division-free variance numerator N*sum(x^2) - (sum x)^2, three-edge pipeline.
module volatility_window_stats #(
  parameter int NUM_STOCKS  = 4,
  parameter int BUFFER_SIZE = 20,
  parameter int DATA_WIDTH  = 32
) (
  input logic                       i_clk,
  input logic                       i_reset_n,
  volatility_window_stats_if.slave  io_bus
);
  localparam int DEPTH = NUM_STOCKS * BUFFER_SIZE;
  localparam int IW    = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int CW    = $clog2(BUFFER_SIZE + 1);
  localparam int SW    = DATA_WIDTH + CW;
  localparam int QW    = 2 * DATA_WIDTH + CW;
  localparam int VW    = 2 * DATA_WIDTH + 2 * CW;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int LW    = DATA_WIDTH + $clog2(NUM_STOCKS + 1);

  logic [DATA_WIDTH-1:0] r_ram [DEPTH];
  logic [DATA_WIDTH-1:0] r_ram_q;

  logic [LW-1:0]         w_limit;
  logic                  w_addr_ok;
  logic                  w_accept;

  logic                  r_s1_valid;
  logic                  r_s1_err;
  logic [IW-1:0]         r_s1_id;
  logic [DATA_WIDTH-1:0] r_s1_price;

  logic [CW-1:0]         r_count [NUM_STOCKS];
  logic [SW-1:0]         r_sum   [NUM_STOCKS];
  logic [QW-1:0]         r_sumsq [NUM_STOCKS];

  logic [CW-1:0]         w_bsize;
  logic [CW-1:0]         w_cnt_cur;
  logic                  w_cnt_full;
  logic [DATA_WIDTH-1:0] w_old;
  logic [PW-1:0]         w_price_x;
  logic [PW-1:0]         w_old_x;
  logic [PW-1:0]         w_p2_new;
  logic [PW-1:0]         w_p2_old;
  logic [CW-1:0]         w_cnt_nxt;
  logic [SW-1:0]         w_sum_nxt;
  logic [QW-1:0]         w_sq_nxt;

  logic                  r_s2_valid;
  logic [IW-1:0]         r_s2_id;
  logic [CW-1:0]         r_s2_count;
  logic [SW-1:0]         r_s2_sum;
  logic [QW-1:0]         r_s2_sumsq;
  logic                  r_s2_full;
  logic [VW-1:0]         w_var_num;

  logic                  r_valid;
  logic [IW-1:0]         r_stock_id;
  logic [CW-1:0]         r_count_out;
  logic [SW-1:0]         r_sum_out;
  logic [VW-1:0]         r_var_num;
  logic                  r_window_full;
  logic                  r_addr_err;

  // The stock region bound follows the runtime window length, not BUFFER_SIZE.
  assign w_limit   = LW'(NUM_STOCKS) * LW'(io_bus.i_buffer_size);
  assign w_addr_ok = LW'(io_bus.i_write_address) < w_limit;
  assign w_accept  = io_bus.i_addr_valid && w_addr_ok;

  // Read-before-write: r_ram_q carries the sample being evicted from this slot.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_ram[io_bus.i_write_address] <= io_bus.i_price;
      r_ram_q                       <= r_ram[io_bus.i_write_address];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_id    <= '0;
      r_s1_price <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_err   <= io_bus.i_addr_valid && !w_addr_ok;
      if (w_accept) begin
        r_s1_id    <= io_bus.i_stock_id;
        r_s1_price <= io_bus.i_price;
      end
    end
  end

  assign w_bsize    = io_bus.i_buffer_size[CW-1:0];
  assign w_cnt_cur  = r_count[r_s1_id];
  assign w_cnt_full = (w_cnt_cur == w_bsize);
  // Until the window is full the RAM slot holds stale data, so nothing is evicted.
  assign w_old      = w_cnt_full ? r_ram_q : '0;
  assign w_price_x  = {{DATA_WIDTH{1'b0}}, r_s1_price};
  assign w_old_x    = {{DATA_WIDTH{1'b0}}, w_old};
  assign w_p2_new   = w_price_x * w_price_x;
  assign w_p2_old   = w_old_x * w_old_x;
  assign w_cnt_nxt  = w_cnt_full ? w_cnt_cur : w_cnt_cur + CW'(1);
  assign w_sum_nxt  = r_sum[r_s1_id] + SW'(r_s1_price) - SW'(w_old);
  assign w_sq_nxt   = r_sumsq[r_s1_id] + QW'(w_p2_new) - QW'(w_p2_old);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        r_count[s] <= '0;
        r_sum[s]   <= '0;
        r_sumsq[s] <= '0;
      end
    end else if (r_s1_valid) begin
      r_count[r_s1_id] <= w_cnt_nxt;
      r_sum[r_s1_id]   <= w_sum_nxt;
      r_sumsq[r_s1_id] <= w_sq_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_count <= '0;
      r_s2_sum   <= '0;
      r_s2_sumsq <= '0;
      r_s2_full  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_id    <= r_s1_id;
        r_s2_count <= w_cnt_nxt;
        r_s2_sum   <= w_sum_nxt;
        r_s2_sumsq <= w_sq_nxt;
        r_s2_full  <= (w_cnt_nxt == w_bsize);
      end
    end
  end

  assign w_var_num = VW'(r_s2_count) * VW'(r_s2_sumsq) - VW'(r_s2_sum) * VW'(r_s2_sum);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid       <= 1'b0;
      r_stock_id    <= '0;
      r_count_out   <= '0;
      r_sum_out     <= '0;
      r_var_num     <= '0;
      r_window_full <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_valid    <= r_s2_valid;
      r_addr_err <= r_s1_err;
      if (r_s2_valid) begin
        r_stock_id    <= r_s2_id;
        r_count_out   <= r_s2_count;
        r_sum_out     <= r_s2_sum;
        r_var_num     <= w_var_num;
        r_window_full <= r_s2_full;
      end
    end
  end

  assign io_bus.o_valid       = r_valid;
  assign io_bus.o_stock_id    = r_stock_id;
  assign io_bus.o_count       = r_count_out;
  assign io_bus.o_sum         = r_sum_out;
  assign io_bus.o_var_num     = r_var_num;
  assign io_bus.o_window_full = r_window_full;
  assign io_bus.o_addr_err    = r_addr_err;
endmodule
